uart_rx_param: RTL and testbench

//  Parametrised, oversampling UART receiver with an internal baud-tick generator and a

---
 rtl/uart_rx_param_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 26 ++
 rtl/uart_rx_param.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_param_pkg.sv
// Shared UART definitions: FSM state encodings and default timing constants,
// reused by the receiver here and the planned parametrised transmitter.
package uart_rx_param_pkg;

  typedef enum logic [2:0] {
    UART_ST_IDLE   = 3'd0,
    UART_ST_START  = 3'd1,
    UART_ST_DATA   = 3'd2,
    UART_ST_PARITY = 3'd3,
    UART_ST_STOP   = 3'd4
  } uart_state_e;

  localparam int UART_DEF_CLK_DIV    = 326;
  localparam int UART_DEF_OVERSAMPLE = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running 0..CLK_DIV-1 counter, tick high for
// one CLK on the terminal count.
module uart_baud_tick
  import uart_rx_param_pkg::*;
#(
  parameter int CLK_DIV = UART_DEF_CLK_DIV
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int            CW   = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST)                count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + CW'(1);
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with valid/ready output register.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
//
// state  | meaning
// IDLE   | line idle, looking for a low level on a tick
// START  | half a bit into the start bit, re-check low (glitch filter)
// DATA   | sample each data bit at mid-bit, LSB first
// PARITY | sample the parity bit and record a mismatch
// STOP   | sample the stop bit, then deliver or flag an error
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int CLK_DIV    = UART_DEF_CLK_DIV,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = UART_DEF_OVERSAMPLE,
  parameter int PARITY_ODD = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int              TCW     = cnt_width(OVERSAMPLE);
  localparam int              BCW     = cnt_width(DATA_BITS);
  localparam logic [TCW-1:0]  TC_HALF = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0]  TC_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0]  BC_LAST = BCW'(DATA_BITS - 1);
  localparam logic            PAR_ODD = (PARITY_ODD != 0);
`ifdef UART_RX_PARITY_EN
  localparam logic            PAR_EN  = 1'b1;
`else
  localparam logic            PAR_EN  = 1'b0;
`endif

  logic tick;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick)
  );

  logic rx_meta, rxs;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  uart_state_e          state, state_n;
  logic [TCW-1:0]       tc, tc_n;
  logic [BCW-1:0]       bc, bc_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bad, par_bad_n;
  logic                 deliver, frame_hit, parity_hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= UART_ST_IDLE;
      tc      <= '0;
      bc      <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      state   <= state_n;
      tc      <= tc_n;
      bc      <= bc_n;
      shreg   <= shreg_n;
      par_bad <= par_bad_n;
    end
  end

  always_comb begin
    state_n    = state;
    tc_n       = tc;
    bc_n       = bc;
    shreg_n    = shreg;
    par_bad_n  = par_bad;
    deliver    = 1'b0;
    frame_hit  = 1'b0;
    parity_hit = 1'b0;

    case (state)
      UART_ST_IDLE: begin
        if (tick && !rxs) begin
          state_n   = UART_ST_START;
          tc_n      = '0;
          par_bad_n = 1'b0;
        end
      end

      UART_ST_START: begin
        if (tick) begin
          if (tc == TC_HALF) begin
            tc_n = '0;
            bc_n = '0;
            state_n = rxs ? UART_ST_IDLE : UART_ST_DATA;
          end else begin
            tc_n = tc + TCW'(1);
          end
        end
      end

      UART_ST_DATA: begin
        if (tick) begin
          if (tc == TC_LAST) begin
            tc_n    = '0;
            shreg_n = {rxs, shreg[DATA_BITS-1:1]};
            bc_n    = bc + BCW'(1);
            if (bc == BC_LAST)
              state_n = PAR_EN ? UART_ST_PARITY : UART_ST_STOP;
          end else begin
            tc_n = tc + TCW'(1);
          end
        end
      end

      UART_ST_PARITY: begin
        if (tick) begin
          if (tc == TC_LAST) begin
            tc_n      = '0;
            par_bad_n = ((^shreg) ^ rxs) != PAR_ODD;
            state_n   = UART_ST_STOP;
          end else begin
            tc_n = tc + TCW'(1);
          end
        end
      end

      UART_ST_STOP: begin
        if (tick) begin
          if (tc == TC_LAST) begin
            tc_n    = '0;
            state_n = UART_ST_IDLE;
            // Framing error takes precedence so the pulses stay exclusive.
            if (!rxs)         frame_hit  = 1'b1;
            else if (par_bad) parity_hit = 1'b1;
            else              deliver    = 1'b1;
          end else begin
            tc_n = tc + TCW'(1);
          end
        end
      end

      default: state_n = UART_ST_IDLE;
    endcase
  end

  // A delivery landing on the acceptance cycle refills the register without overrun.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= frame_hit;
      parity_err <= parity_hit;
      overrun    <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param (CLK_DIV=4, OVERSAMPLE=16, DATA_BITS=8).
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int BIT = 64;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun;

  uart_rx_param #(
    .CLK_DIV(4), .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_ODD(0)
  ) dut (
    .CLK(CLK), .RST(RST), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0, n_bad = 0;
  int v_cnt = 0, a_cnt = 0, fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, ov_cyc = 0;
  logic [7:0] a_data = '0;
  int b_v, b_a, b_fe, b_pe, b_ov;
  int rst_cyc = 0, ov_rel = 0;
  bit hit;

  always @(negedge CLK) begin
    if (!RST) begin
      if (rx_valid) v_cnt++;
      if (rx_valid && rx_ready) begin
        a_cnt++;
        a_data = rx_data;
      end
      if (frame_err)  fe_cnt++;
      if (parity_err) pe_cnt++;
      if (overrun) begin
        ov_cnt++;
        ov_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_v = v_cnt; b_a = a_cnt; b_fe = fe_cnt; b_pe = pe_cnt; b_ov = ov_cnt;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    rst_cyc = cyc;
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BIT) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b);
`endif
    drive_bit(stop_b);
    rxd = 1'b1;
  endtask

  task automatic set_ready(input logic r);
    @(posedge CLK);
    #1 rx_ready = r;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge CLK);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ovr", overrun, 0);
    do_reset();

    // 1: clean frame 0x35
    set_ready(1'b1);
    @(negedge CLK);
    snap();
    send_frame(8'h35, 1'b1, ^8'h35);
    repeat (8) @(negedge CLK);
    chk("t1_acc", a_cnt - b_a, 1);
    chk("t1_vcyc", v_cnt - b_v, 1);
    chk("t1_data", a_data, 8'h35);
    chk("t1_errs", (fe_cnt - b_fe) + (pe_cnt - b_pe) + (ov_cnt - b_ov), 0);

    // 2: 4-tick start glitch, then 0x2D
    snap();
    rxd = 1'b0;
    repeat (16) @(negedge CLK);
    rxd = 1'b1;
    repeat (2 * BIT) @(negedge CLK);
    chk("t2_glitch_v", v_cnt - b_v, 0);
    chk("t2_glitch_e", (fe_cnt - b_fe) + (pe_cnt - b_pe) + (ov_cnt - b_ov), 0);
    send_frame(8'h2D, 1'b1, ^8'h2D);
    repeat (8) @(negedge CLK);
    chk("t2_acc", a_cnt - b_a, 1);
    chk("t2_data", a_data, 8'h2D);

    // 3: 0xA5 with stop bit low
    snap();
    send_frame(8'hA5, 1'b0, ^8'hA5);
    repeat (3 * BIT) @(negedge CLK);
    chk("t3_ferr", fe_cnt - b_fe, 1);
    chk("t3_valid", v_cnt - b_v, 0);
    chk("t3_other", (pe_cnt - b_pe) + (ov_cnt - b_ov), 0);

`ifdef UART_RX_PARITY_EN
    // 6a: 0x07 with wrong even parity
    snap();
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (8) @(negedge CLK);
    chk("t6_perr", pe_cnt - b_pe, 1);
    chk("t6_valid", v_cnt - b_v, 0);
    chk("t6_ferr", fe_cnt - b_fe, 0);
`endif

    // 4: back-to-back 0x2B, 0x2D with rx_ready low
    rx_ready = 1'b0;
    do_reset();
    snap();
    send_frame(8'h2B, 1'b1, ^8'h2B);
    send_frame(8'h2D, 1'b1, ^8'h2D);
    repeat (8) @(negedge CLK);
    ov_rel = ov_cyc - rst_cyc;
    chk("t4_ovr", ov_cnt - b_ov, 1);
    chk("t4_valid", rx_valid, 1);
    chk("t4_held", rx_data, 8'h2B);
    chk("t4_noacc", a_cnt - b_a, 0);
    set_ready(1'b1);
    set_ready(1'b0);
    repeat (2) @(negedge CLK);
    chk("t4_acc", a_cnt - b_a, 1);
    chk("t4_accdata", a_data, 8'h2B);
    chk("t4_cleared", rx_valid, 0);

    // 5: accept exactly on the second delivery cycle
    do_reset();
    snap();
    hit = 1'b0;
    fork
      begin
        send_frame(8'h2B, 1'b1, ^8'h2B);
        send_frame(8'h2D, 1'b1, ^8'h2D);
      end
      begin
        for (int k = 0; k < 3000 && !hit; k++) begin
          @(posedge CLK);
          #1;
          if (cyc - rst_cyc == ov_rel - 1) begin
            rx_ready = 1'b1;
            hit = 1'b1;
            @(posedge CLK);
            #1 rx_ready = 1'b0;
          end
        end
      end
    join
    repeat (8) @(negedge CLK);
    chk("t5_hit", hit, 1);
    chk("t5_ovr", ov_cnt - b_ov, 0);
    chk("t5_valid", rx_valid, 1);
    chk("t5_data", rx_data, 8'h2D);
    chk("t5_acc", a_cnt - b_a, 1);

    // 6b: reset during data bit 3 of 0x39 while 0x2D is still held
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rxd = 1'b1;
    repeat (BIT / 2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("t6_rst_out", {rx_data, rx_valid, frame_err, parity_err, overrun}, 0);
    RST = 1'b0;
    repeat (BIT) @(negedge CLK);
    chk("t6_quiet", {rx_valid, frame_err, parity_err, overrun}, 0);
    set_ready(1'b1);
    @(negedge CLK);
    snap();
    send_frame(8'h39, 1'b1, ^8'h39);
    repeat (8) @(negedge CLK);
    chk("t6_acc", a_cnt - b_a, 1);
    chk("t6_data", a_data, 8'h39);
    chk("t6_errs", (fe_cnt - b_fe) + (pe_cnt - b_pe) + (ov_cnt - b_ov), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
